// File: rtl/useq_pkg.sv
// useq_pkg: definitions shared by the useq core and its host port.
//   uh_state_e            host port FSM states (UH_IDLE/UH_CAPTURE/UH_GAP)
//   UH_GAP_CYCLES_DEFAULT default idle gap after each host FIFO operation
//   USEQ_FIFO_DEPTH       message FIFO depth used by the core instantiation
package useq_pkg;

  typedef enum logic [1:0] {
    UH_IDLE    = 2'd0,
    UH_CAPTURE = 2'd1,
    UH_GAP     = 2'd2
  } uh_state_e;

  localparam int unsigned UH_GAP_CYCLES_DEFAULT = 2;
  localparam int unsigned USEQ_FIFO_DEPTH       = 16;

endpackage

// File: rtl/useq_host_port_if.sv
// useq_host_port_if: the useq core message FIFO port.
//   read_fifo/write_fifo  pop/push strobes (host -> core)
//   fifo_in               push data (host -> core)
//   fifo_empty/fifo_full  core FIFO flags (core -> host)
//   fifo_out              pop data, valid the cycle after read_fifo (core -> host)
// master = host side driving the strobes, slave = core side.
interface useq_host_port_if;
  logic       read_fifo;
  logic       write_fifo;
  logic [7:0] fifo_in;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_out;

  modport master (
    output read_fifo, write_fifo, fifo_in,
    input  fifo_empty, fifo_full, fifo_out
  );

  modport slave (
    input  read_fifo, write_fifo, fifo_in,
    output fifo_empty, fifo_full, fifo_out
  );
endinterface

// File: rtl/useq_host_port.sv
// useq_host_port: host-side master for the useq message FIFO port.
// Pushes an upstream byte stream into the core FIFO and drains core bytes
// into a downstream byte stream, leaving GAP_CYCLES idle cycles after every
// FIFO operation because each host access stalls the core.
//   clk, rst              clock, synchronous active-high reset
//   s_data/s_valid/s_ready upstream bytes to push (s_ready = accepted now)
//   m_data/m_valid/m_ready downstream drained bytes
//   drain_en              permits reads from the core FIFO
//   fifo_bus              core FIFO port (master modport)
//   busy                  FSM not in IDLE
module useq_host_port
  import useq_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = UH_GAP_CYCLES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  input  logic                     drain_en,
  useq_host_port_if.master         fifo_bus,
  output logic                     busy
);

  uh_state_e  state_q;
  logic [7:0] gap_cnt_q;
  logic       last_was_read_q;
  logic [7:0] m_data_q;
  logic       m_valid_q;

  logic wr_elig, rd_elig, issue_wr, issue_rd;

  // Flags are sampled in the very cycle the strobe goes out, so a concurrent
  // core-side push/pop cannot turn into a read on empty or write on full.
  always_comb begin
    wr_elig  = s_valid && !fifo_bus.fifo_full;
    rd_elig  = drain_en && !fifo_bus.fifo_empty && !m_valid_q;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    if (!rst && state_q == UH_IDLE) begin
      // Round-robin on contention: whichever went last yields.
      issue_wr = wr_elig && (!rd_elig || last_was_read_q);
      issue_rd = rd_elig && (!wr_elig || !last_was_read_q);
    end
  end

  assign s_ready             = issue_wr;
  assign fifo_bus.write_fifo = issue_wr;
  assign fifo_bus.fifo_in    = issue_wr ? s_data : '0;
  assign fifo_bus.read_fifo  = issue_rd;
  assign m_data              = m_data_q;
  assign m_valid             = m_valid_q;
  assign busy                = (state_q != UH_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= UH_IDLE;
      gap_cnt_q       <= '0;
      last_was_read_q <= 1'b1;
      m_data_q        <= '0;
      m_valid_q       <= 1'b0;
    end else begin
      if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end
      unique case (state_q)
        UH_IDLE: begin
          if (issue_wr) begin
            last_was_read_q <= 1'b0;
            gap_cnt_q       <= 8'(GAP_CYCLES - 1);
            state_q         <= UH_GAP;
          end else if (issue_rd) begin
            last_was_read_q <= 1'b1;
            state_q         <= UH_CAPTURE;
          end
        end
        UH_CAPTURE: begin
          m_data_q  <= fifo_bus.fifo_out;
          m_valid_q <= 1'b1;
          gap_cnt_q <= 8'(GAP_CYCLES - 1);
          state_q   <= UH_GAP;
        end
        UH_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= UH_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: state_q <= UH_IDLE;
      endcase
    end
  end

endmodule

// File: doc/useq_host_port.md
# useq_host_port

Host-side master for the useq core's message FIFO port: it drives `read_fifo`/`write_fifo`/`fifo_in` and observes `fifo_empty`/`fifo_full`/`fifo_out`. It converts an upstream byte stream into core FIFO pushes and drains core FIFO bytes into a downstream byte stream. Every host FIFO operation stalls the core for that cycle, so the block enforces a programmable idle gap after each operation. It sits between the useq instance and a host-side transport such as a UART or SPI bridge.

## Interface
- `GAP_CYCLES`, 2: idle cycles after each FIFO operation; legal range 1..255.
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `s_data`  in  8  byte to push into the core FIFO.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  byte accepted this cycle; reset 0.
- `m_data`  out  8  byte drained from the core FIFO; reset 0.
- `m_valid`  out  1  `m_data` valid; reset 0.
- `m_ready`  in  1  downstream accepts `m_data`.
- `drain_en`  in  1  permits reads from the core FIFO.
- `write_fifo`  out  1  push strobe to the core; reset 0.
- `read_fifo`  out  1  pop strobe to the core; reset 0.
- `fifo_in`  out  8  push data to the core; equals `s_data` while `write_fifo`=1, otherwise 0.
- `fifo_empty`  in  1  core FIFO empty.
- `fifo_full`  in  1  core FIFO full.
- `fifo_out`  in  8  core pop data, valid the cycle after `read_fifo`.
- `busy`  out  1  state ≠ IDLE; reset 0.

## Operation
- **States:** IDLE, CAPTURE, GAP.
- **Eligibility, evaluated in IDLE only:**
  - Write is eligible when `s_valid` && !`fifo_full`.
  - Read is eligible when `drain_en` && !`fifo_empty` && !`m_valid`.
- **Arbitration when both are eligible:** round-robin using a `last_was_read` register.
  - Reset value is 1, so the first contention goes to write.
  - The register updates on every issued operation.
- **Write issued:**
  - `s_ready`=1, `write_fifo`=1 and `fifo_in`=`s_data`, all in the same cycle and combinational from state and inputs.
  - Next state is GAP.
- **Read issued:**
  - `read_fifo`=1 in the same cycle; next state is CAPTURE.
  - In CAPTURE: `m_data` <= `fifo_out` and `m_valid` <= 1; next state is GAP.
- **GAP:**
  - Loads a counter with `GAP_CYCLES`-1 on entry and decrements it.
  - Returns to IDLE when the counter is 0.
  - Both strobes are low throughout; the core runs during the gap and the flags settle.
- **Strobes:**
  - `write_fifo` and `read_fifo` are never both 1; both high would be ignored by the core.
  - Each strobe is exactly 1 cycle wide.
- **Output buffer:** `m_valid` clears on `m_valid` && `m_ready`; it holds indefinitely under backpressure.
- **Nothing eligible:** the block stays in IDLE with all strobes 0.
- **Reset mid-operation:**
  - State returns to IDLE and strobes drop in the same cycle.
  - `m_valid` clears, so a captured but unaccepted byte is discarded.
  - A strobe issued in the reset cycle is not issued.
- **Flag race:** flags are sampled in the same cycle the strobe is asserted, so a concurrent core-side push or pop can never produce a read on empty or a write on full.

## Timing
- **Write:** handshake and `write_fifo` in cycle 0; GAP occupies cycles 1..`GAP_CYCLES`; next issue is possible at cycle `GAP_CYCLES`+1.
- **Read:** `read_fifo` in cycle 0, CAPTURE in cycle 1, `m_valid`=1 from cycle 2; GAP occupies cycles 2..`GAP_CYCLES`+1; next issue is possible at cycle `GAP_CYCLES`+2.
- **Minimum gap:** with `GAP_CYCLES`=1 the block still guarantees at least one non-strobe cycle between operations.
- **Throughput:**
  - Pushes, one byte per `GAP_CYCLES`+1 cycles.
  - Drains, one byte per `GAP_CYCLES`+2 cycles when `m_ready` is tied high.

## Structure
- Shared package `useq_pkg` holds:
  - state encodings `UH_IDLE`=0, `UH_CAPTURE`=1, `UH_GAP`=2;
  - the default `GAP_CYCLES` constant;
  - `USEQ_FIFO_DEPTH`=16, shared with the core instantiation.
- No sub-module: the arbiter, 8-bit gap counter and output register are all local.

## Test plan
- **Single push:** reset, then `s_valid`=1, `s_data`=8'hA5, `fifo_full`=0 → same cycle `s_ready`=1, `write_fifo`=1, `fifo_in`=8'hA5; strobes 0 for the next 2 cycles; `busy`=0 on the 3rd cycle.
- **Drain to output:** `drain_en`=1, `fifo_empty`=0, core presents `fifo_out`=8'h3C the cycle after `read_fifo` → `m_data`=8'h3C and `m_valid`=1 two cycles after `read_fifo`; no further read while `m_valid`=1 and `m_ready`=0.
- **Contention:** both eligible continuously, `m_ready`=1 → issued sequence is W, R, W, R with no cycle having both strobes high.
- **Boundaries:**
  - `fifo_full`=1 with `s_valid`=1 → `s_ready`=0 and `write_fifo`=0 indefinitely.
  - `fifo_empty`=1 with `drain_en`=1 → `read_fifo` never asserted.
- **Gap parameter:** with `GAP_CYCLES`=5, back-to-back pushes → `write_fifo` pulses exactly 6 cycles apart.
- **Reset mid-operation:** assert `rst` in the CAPTURE cycle → next cycle `m_valid`=0, `busy`=0, both strobes 0, and normal operation resumes after `rst` deasserts.
